// File: rtl/stack_arbiter_if.sv
// stack_arbiter_if: requester-side bus of the stack arbiter.
// The master drives requests; the slave (arbiter) answers with grants, responses and occupancy.
interface stack_arbiter_if #(
    parameter int DIR_LEN = 2,
    parameter int SIZE    = 256
);
    localparam int CNT_W = $clog2(SIZE + 1);
    logic               req0;
    logic               req1;
    logic               op0;
    logic               op1;
    logic [DIR_LEN-1:0] wdata0;
    logic [DIR_LEN-1:0] wdata1;
    logic               gnt0;
    logic               gnt1;
    logic               rsp_valid;
    logic               rsp_id;
    logic [DIR_LEN-1:0] rsp_data;
    logic               err;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    modport master (
        output req0, req1, op0, op1, wdata0, wdata1,
        input  gnt0, gnt1, rsp_valid, rsp_id, rsp_data, err, count, full, empty
    );
    modport slave (
        input  req0, req1, op0, op1, wdata0, wdata1,
        output gnt0, gnt1, rsp_valid, rsp_id, rsp_data, err, count, full, empty
    );
endinterface

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin sharing of one direction stack between two requesters.
// Defining STACK_ARB_FLUSH_EN adds a flush/flush_done port pair that empties the stack.
module stack_arbiter #(
    parameter int DIR_LEN = 2,
    parameter int SIZE    = 256
) (
    input  logic               clk,
    input  logic               rst,
`ifdef STACK_ARB_FLUSH_EN
    input  logic               flush,
    output logic               flush_done,
`endif
    stack_arbiter_if.slave     bus,
    output logic               stk_push,
    output logic               stk_pop,
    output logic [DIR_LEN-1:0] stk_data_in,
    input  logic [DIR_LEN-1:0] stk_data_out
);
    localparam int CNT_W = $clog2(SIZE + 1);
`ifdef STACK_ARB_FLUSH_EN
    typedef enum logic [1:0] {IDLE, POP_RSP, FLUSH} state_t;
`else
    typedef enum logic [1:0] {IDLE, POP_RSP} state_t;
`endif
    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count;
    logic               rr_last;
    logic               pop_id;
    logic               sel;
    logic               op;
    logic               fl;
    logic               idle_go;
    logic               push_ok;
    logic               pop_ok;
    logic [DIR_LEN-1:0] wd;
`ifdef STACK_ARB_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif
    assign bus.count = count;
    assign bus.full  = count == CNT_W'(SIZE);
    assign bus.empty = count == '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            count   <= '0;
            rr_last <= 1'b1;
            pop_id  <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= stk_push ? count + CNT_W'(1) : stk_pop ? count - CNT_W'(1) : count;
            rr_last <= idle_go ? sel : rr_last;
            pop_id  <= pop_ok ? sel : pop_id;
        end
    end
    // Grants are combinational from the requests while idle; flush request outranks them.
    always_comb begin
        sel           = (bus.req0 && bus.req1) ? !rr_last : bus.req1;
        op            = sel ? bus.op1 : bus.op0;
        wd            = sel ? bus.wdata1 : bus.wdata0;
        idle_go       = state == IDLE && (bus.req0 || bus.req1) && !fl;
        push_ok       = idle_go && !op && !bus.full;
        pop_ok        = idle_go && op && !bus.empty;
        bus.gnt0      = idle_go && !sel;
        bus.gnt1      = idle_go && sel;
        bus.err       = idle_go && !push_ok && !pop_ok;
        bus.rsp_valid = state == POP_RSP;
        bus.rsp_data  = bus.rsp_valid ? stk_data_out : '0;
        bus.rsp_id    = bus.err ? sel : (bus.rsp_valid && pop_id);
        stk_push      = push_ok;
        stk_data_in   = push_ok ? wd : '0;
        stk_pop       = pop_ok;
        state_nxt     = pop_ok ? POP_RSP : IDLE;
`ifdef STACK_ARB_FLUSH_EN
        flush_done    = state == FLUSH && count == '0;
        stk_pop       = pop_ok || (state == FLUSH && count != '0);
        state_nxt     = (state == IDLE && flush) || (state == FLUSH && count != '0) ? FLUSH :
                        pop_ok ? POP_RSP : IDLE;
`endif
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed and random checks of stack_arbiter against a queue-based model.
// Define STACK_ARB_FLUSH_EN for both files to exercise the flush path.
module tb_stack_arbiter;
    localparam int SIZE = 16;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stk_push;
    logic       stk_pop;
    logic [1:0] stk_data_in;
    logic [1:0] stk_data_out;
    logic [1:0] mem [SIZE];
    int         sp;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [1:0] q [$];
    logic       m_last;
    logic       m_rsp;
    logic       m_id;
    logic [1:0] m_data;
`ifdef STACK_ARB_FLUSH_EN
    logic       flush = 1'b0;
    logic       flush_done;
`endif
    stack_arbiter_if #(.DIR_LEN(2), .SIZE(SIZE)) bus ();
    stack_arbiter #(.DIR_LEN(2), .SIZE(SIZE)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef STACK_ARB_FLUSH_EN
        .flush        (flush),
        .flush_done   (flush_done),
`endif
        .bus          (bus.slave),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out)
    );
    always #5 clk = ~clk;
    // Attached stack: top word appears on stk_data_out the cycle after a pop.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp           <= 0;
            stk_data_out <= '0;
        end else if (stk_push && sp < SIZE) begin
            mem[sp] <= stk_data_in;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_data_out <= mem[sp-1];
            sp           <= sp - 1;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic r0, input logic r1, input logic o0, input logic o1,
                         input logic [1:0] w0, input logic [1:0] w1);
        bus.req0 = r0;
        bus.req1 = r1;
        bus.op0 = o0;
        bus.op1 = o1;
        bus.wdata0 = w0;
        bus.wdata1 = w1;
    endtask
    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_flags", {bus.full, bus.empty, bus.gnt0, bus.gnt1, bus.err, stk_push, stk_pop}, 7'b0100000);
        q.delete();
        m_rsp = 1'b0;
        m_last = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask
    task automatic step(input logic r0, input logic r1, input logic o0, input logic o1,
                        input logic [1:0] w0, input logic [1:0] w1);
        logic e_g0, e_g1, e_err, e_rv, e_id, e_push, e_pop, id, op;
        logic [1:0] e_rd, w;
        int pre;
        drive(r0, r1, o0, o1, w0, w1);
        @(negedge clk);
        {e_g0, e_g1, e_err, e_rv, e_id, e_push, e_pop, e_rd, w} = '0;
        pre = q.size();
        if (m_rsp) begin
            e_rv = 1'b1;
            e_id = m_id;
            e_rd = m_data;
            m_rsp = 1'b0;
        end else if (r0 || r1) begin
            id = (r0 && r1) ? !m_last : r1;
            m_last = id;
            op = id ? o1 : o0;
            w = id ? w1 : w0;
            e_g0 = !id;
            e_g1 = id;
            if (!op && q.size() == SIZE || op && q.size() == 0) begin
                e_err = 1'b1;
                e_id = id;
            end else if (!op) begin
                e_push = 1'b1;
                q.push_back(w);
            end else begin
                e_pop = 1'b1;
                m_rsp = 1'b1;
                m_id = id;
                m_data = q.pop_back();
            end
        end
        chk("gnt", {bus.gnt1, bus.gnt0}, {e_g1, e_g0});
        chk("err", bus.err, e_err);
        chk("rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, {e_rv, e_id, e_rd});
        chk("count", bus.count, pre);
        chk("flags", {bus.full, bus.empty}, {pre == SIZE, pre == 0});
        chk("stk_ctl", {stk_push, stk_pop}, {e_push, e_pop});
        if (e_push) chk("stk_din", stk_data_in, w);
        @(posedge clk);
        #1;
    endtask
    initial begin
        do_reset();
        // r0 pushes three words back to back, r1 pops them in reverse
        step(1, 0, 0, 0, 2'b01, 0);
        step(1, 0, 0, 0, 2'b10, 0);
        step(1, 0, 0, 0, 2'b11, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 0, 0);
        // both requesters push simultaneously after reset
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 2'(i), 2'(3 - i));
        // underflow and overflow rejection
        do_reset();
        step(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < SIZE; i++) step(0, 1, 0, 0, 0, 2'(i));
        step(1, 0, 0, 0, 2'b11, 0);
        step(0, 1, 0, 0, 0, 2'b10);
        // reset while a pop response is pending
        step(0, 1, 0, 1, 0, 0);
        do_reset();
        step(1, 0, 1, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
                 2'($urandom), 2'($urandom));
`ifdef STACK_ARB_FLUSH_EN
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 2'(i), 0);
        drive(1, 0, 0, 0, 0, 0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle", {bus.gnt0, bus.gnt1, stk_pop, flush_done}, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("flush_pop", {stk_pop, flush_done, bus.gnt0, bus.rsp_valid}, 4'b1000);
            chk("flush_cnt", bus.count, 5 - i);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("flush_done", {flush_done, stk_pop, bus.empty}, 3'b101);
        chk("flush_cnt0", bus.count, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("flush_end", flush_done, 0);
        q.delete();
        @(posedge clk);
        #1;
        step(0, 1, 0, 1, 0, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
